// File: rtl/sys_defs_pkg.sv
// Shared bus definitions: command encodings, requester IDs and the tag-owner entry.
package sys_defs;

  localparam int SYS_XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  typedef enum logic [1:0] {
    REQ_DC   = 2'd0,
    REQ_IC   = 2'd1,
    REQ_PF   = 2'd2,
    REQ_NONE = 2'd3
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
    logic    discard;
  } owner_entry_t;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for outstanding load tags: allocate on acceptance, retire on data
// return, mark prefetch entries as discard on a flush, combinational lookup.
module mem_tag_table
  import sys_defs::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  req_id_t          alloc_owner,
  input  logic             flush,
  input  logic [TAG_W-1:0] lookup_tag,
  output owner_entry_t     lookup_entry
);

  localparam int DEPTH = 2 ** TAG_W;

  owner_entry_t entry_reg  [DEPTH];
  owner_entry_t entry_next [DEPTH];
  logic         retire;

  assign lookup_entry = entry_reg[lookup_tag];
  assign retire       = (lookup_tag != '0) && entry_reg[lookup_tag].valid;

  // Retire, then flush-mark, then allocate: an allocation to the tag being
  // retired in the same cycle overwrites the retired entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i] = entry_reg[i];
      if (i != 0) begin
        if (retire && (int'(lookup_tag) == i)) entry_next[i].valid = 1'b0;
        if (flush && entry_next[i].valid && (entry_next[i].owner == REQ_PF))
          entry_next[i].discard = 1'b1;
        if (alloc_en && (int'(alloc_tag) == i)) begin
          entry_next[i].valid   = 1'b1;
          entry_next[i].owner   = alloc_owner;
          entry_next[i].discard = flush && (alloc_owner == REQ_PF);
        end
      end else begin
        entry_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) entry_reg[i] <= '0;
      else     entry_reg[i] <= entry_next[i];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-rank arbiter sharing one memory bus between D-cache, I-cache and prefetcher,
// with tag-based data steering and prefetch anti-starvation promotion.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int TAG_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          dc_cmd,
  input  logic [SYS_XLEN-1:0] dc_addr,
  input  logic [63:0]         dc_data,
  input  logic [1:0]          ic_cmd,
  input  logic [SYS_XLEN-1:0] ic_addr,
  input  logic [1:0]          pf_cmd,
  input  logic [SYS_XLEN-1:0] pf_addr,
  input  logic                pf_flush,
  input  logic [TAG_W-1:0]    mem2proc_response,
  input  logic [TAG_W-1:0]    mem2proc_tag,
  output logic [1:0]          proc2mem_cmd,
  output logic [SYS_XLEN-1:0] proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  output logic [TAG_W-1:0]    dc_response,
  output logic [TAG_W-1:0]    ic_response,
  output logic [TAG_W-1:0]    pf_response,
  output logic [TAG_W-1:0]    dc_tag,
  output logic [TAG_W-1:0]    ic_tag,
  output logic [TAG_W-1:0]    pf_tag,
  output logic                pf_bus_priority,
  output logic                tag_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic         dc_act, ic_act, pf_act;
  req_id_t      winner;
  logic         accepted, alloc_en, tag_hit;
  owner_entry_t lookup;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic         prio_reg, tag_err_reg;

  assign dc_act = dc_cmd != BUS_NONE;
  assign ic_act = ic_cmd != BUS_NONE;
  assign pf_act = pf_cmd != BUS_NONE;

  always_comb begin
    winner = REQ_NONE;
    if (!rst) begin
      if (dc_act)                  winner = REQ_DC;
      else if (prio_reg && pf_act) winner = REQ_PF;
      else if (ic_act)             winner = REQ_IC;
      else if (pf_act)             winner = REQ_PF;
    end
  end

  always_comb begin
    proc2mem_cmd  = BUS_NONE;
    proc2mem_addr = '0;
    proc2mem_data = '0;
    case (winner)
      REQ_DC: begin
        proc2mem_cmd  = dc_cmd;
        proc2mem_addr = dc_addr;
        proc2mem_data = dc_data;
      end
      REQ_IC: begin
        proc2mem_cmd  = ic_cmd;
        proc2mem_addr = ic_addr;
      end
      REQ_PF: begin
        proc2mem_cmd  = pf_cmd;
        proc2mem_addr = pf_addr;
      end
      default: ;
    endcase
  end

  assign dc_response = (winner == REQ_DC) ? mem2proc_response : '0;
  assign ic_response = (winner == REQ_IC) ? mem2proc_response : '0;
  assign pf_response = (winner == REQ_PF) ? mem2proc_response : '0;

  assign accepted = (winner != REQ_NONE) && (mem2proc_response != '0);
  assign alloc_en = accepted && (proc2mem_cmd == BUS_LOAD);

  mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (winner),
    .flush        (pf_flush),
    .lookup_tag   (mem2proc_tag),
    .lookup_entry (lookup)
  );

  assign tag_hit = !rst && (mem2proc_tag != '0) && lookup.valid && !lookup.discard;
  assign dc_tag  = (tag_hit && lookup.owner == REQ_DC) ? mem2proc_tag : '0;
  assign ic_tag  = (tag_hit && lookup.owner == REQ_IC) ? mem2proc_tag : '0;
  assign pf_tag  = (tag_hit && lookup.owner == REQ_PF) ? mem2proc_tag : '0;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!pf_act || (accepted && winner == REQ_PF)) starve_cnt_next = '0;
    else if (starve_cnt_reg != LIMIT)              starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      prio_reg       <= 1'b0;
      tag_err_reg    <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      prio_reg       <= (starve_cnt_next == LIMIT);
      if ((mem2proc_tag != '0) && !lookup.valid) tag_err_reg <= 1'b1;
    end
  end

  assign pf_bus_priority = prio_reg;
  assign tag_err         = tag_err_reg;

endmodule
